// File: rtl/secded_pkg.sv
// SEC/DED codec shared types and helpers.
// Codeword math is written over positions, sized for the widest word.
package secded_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_CW = 72;

  typedef logic [MAX_DW-1:0] dword_t;
  typedef logic [MAX_CW-1:0] cword_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  function automatic int calc_p_w(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic bit pos_is_data(input int k);
    return (k & (k - 1)) != 0;
  endfunction

  function automatic logic [6:0] secded_syndrome(
    input cword_t cw,
    input int     cw_w
  );
    logic [6:0] s;
    s = '0;
    for (int k = 1; k < MAX_CW; k++)
      if (k < cw_w && cw[k[6:0]]) s ^= k[6:0];
    return s;
  endfunction

  function automatic cword_t secded_encode(
    input dword_t d,
    input int     cw_w
  );
    cword_t c;
    int     j;
    c = '0;
    j = 0;
    for (int k = 1; k < MAX_CW; k++)
      if (k < cw_w && pos_is_data(k)) begin
        c[k[6:0]] = d[j[5:0]];
        j++;
      end
    for (int i = 0; i < 7; i++) begin
      int   pos;
      logic p;
      pos = 1 << i;
      p   = 1'b0;
      for (int k = 1; k < MAX_CW; k++)
        if (k < cw_w && ((k >> i) & 1) == 1) p ^= c[k[6:0]];
      if (pos < cw_w) c[pos[6:0]] = p;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic dword_t secded_extract(
    input cword_t c,
    input int     cw_w
  );
    dword_t d;
    int     j;
    d = '0;
    j = 0;
    for (int k = 1; k < MAX_CW; k++)
      if (k < cw_w && pos_is_data(k)) begin
        d[j[5:0]] = c[k[6:0]];
        j++;
      end
    return d;
  endfunction

endpackage

// File: rtl/secded_pipe_stage.sv
// Generic valid/ready payload register.
// Accepts a new beat whenever empty or being drained downstream.
module secded_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Load on accept; hold payload while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/secded_codec_pipe.sv
// Two-stage pipelined SEC/DED encoder/decoder.
// Stage 1 latches input with syndrome; stage 2 latches result and flags.
module secded_codec_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 16,
  localparam int P_W    = calc_p_w(DATA_W),
  localparam int CW_W   = DATA_W + P_W + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [CW_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW_W-1:0] out_word,
  output logic            out_single,
  output logic            out_double,
  output logic [P_W-1:0]  out_syndrome,
  input  logic            cnt_clear,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  typedef struct packed {
    mode_e           mode;
    logic [CW_W-1:0] word;
    logic [P_W-1:0]  syn;
    logic            par;
  } in_s1_t;

  typedef struct packed {
    logic [CW_W-1:0] word;
    logic            single;
    logic            dbl;
    logic [P_W-1:0]  syn;
  } s1_out_t;

  in_s1_t  s1_d, s1_q;
  s1_out_t s2_d, s2_q;
  logic    s1_valid, s2_ready;
  logic    in_range, single_hit;
  logic [CW_W-1:0] fixed;

  // Syndrome and overall parity of the incoming word.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = mode_e'(in_mode);
    s1_d.word = in_data;
    s1_d.syn  = P_W'(secded_syndrome(MAX_CW'(in_data), CW_W));
    s1_d.par  = ^in_data;
  end

  assign in_range = int'(s1_q.syn) < CW_W;

  // Encode, or classify, correct and extract.
  always_comb begin
    s2_d       = '0;
    single_hit = 1'b0;
    fixed      = s1_q.word;
    if (s1_q.mode == MODE_ENC) begin
      s2_d.word = CW_W'(secded_encode(
        MAX_DW'(s1_q.word[DATA_W-1:0]), CW_W));
    end else begin
      single_hit = s1_q.par && in_range;
      if (single_hit)
        fixed = s1_q.word ^ (CW_W'(1) << s1_q.syn);
      s2_d.word   = CW_W'(secded_extract(MAX_CW'(fixed), CW_W));
      s2_d.single = single_hit;
      s2_d.dbl    = (s1_q.par && !in_range) ||
                    (!s1_q.par && s1_q.syn != '0);
      s2_d.syn    = s1_q.syn;
    end
  end

  secded_pipe_stage #(.W($bits(in_s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  secded_pipe_stage #(.W($bits(s1_out_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_word     = s2_q.word;
  assign out_single   = s2_q.single;
  assign out_double   = s2_q.dbl;
  assign out_syndrome = s2_q.syn;

  // Saturating error statistics; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (cnt_clear) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (out_valid && out_ready) begin
      if (s2_q.single && cnt_single != '1)
        cnt_single <= cnt_single + CNT_W'(1);
      if (s2_q.dbl && cnt_double != '1)
        cnt_double <= cnt_double + CNT_W'(1);
    end
  end

endmodule

// File: doc/secded_codec_pipe.md
Name: secded_codec_pipe

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational SEC/DED benchmark circuit.
- A single block that either encodes data into an extended-Hamming codeword or decodes a codeword with single-error correction and double-error detection. The mode is selected per transaction.
- Sits between a producer and a consumer using valid/ready handshakes on both sides.
- Keeps saturating error statistics for software readout.

Parameters:
- DATA_W, 16, data bits per word (4..64).
- P_W, derived, Hamming check bits: the smallest p with 2^p >= DATA_W + p + 1 (5 for DATA_W = 16).
- CW_W, derived, codeword width = DATA_W + P_W + 1 (22 for DATA_W = 16).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_mode  in  1  0 = encode, 1 = decode.
- in_data  in  CW_W  encode: bits [DATA_W-1:0] carry data, upper bits are ignored; decode: full codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_word  out  CW_W  encode: codeword; decode: corrected data, zero-extended.
- out_single  out  1  decode only: a single error was corrected.
- out_double  out  1  decode only: an uncorrectable double error was detected.
- out_syndrome  out  P_W  decode syndrome; 0 in encode mode.
- cnt_clear  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  number of corrected single errors, saturating.
- cnt_double  out  CNT_W  number of detected double errors, saturating.

Behaviour:
- Codeword layout:
  - Codeword bit 0 is the overall even parity over bits 1..CW_W-1.
  - Bit k (k >= 1) is Hamming position k. Check bit p_i sits at position 2^i.
  - Data bits fill the non-power-of-2 positions in ascending order. For DATA_W = 16: d0 at 3, d1 at 5, d2 at 6, d3 at 7, d4..d10 at 9..15, d11..d15 at 17..21.
  - Check bit p_i is the XOR of all positions k whose bit i is set.
- Decode:
  - syndrome = XOR of the indices of all set positions 1..CW_W-1.
  - par = XOR of all CW_W bits.
  - syndrome = 0 and par = 0: clean; data passes through.
  - par = 1: single error. Flip position syndrome (syndrome 0 means bit 0 itself is in error), then extract data. out_single = 1.
  - syndrome != 0 and par = 0: double error. out_double = 1; data is extracted uncorrected.
  - par = 1 with syndrome >= CW_W: classified as double (out_double = 1, no flip).
- Pipeline:
  - Two register stages. Stage 1 registers mode, input and syndrome/parity. Stage 2 registers the corrected or encoded result and the flags.
  - Latency is exactly 2 cycles from an accepted input beat to out_valid when out_ready is held high.
  - Throughput is 1 beat per cycle.
- Handshake:
  - A beat transfers when valid and ready are both high.
  - Once out_valid rises, out_valid, out_word and the flags hold stable until out_ready.
  - in_ready = !stage2_full || out_ready || !stage1_full, i.e. a standard pipelined ready with no bubble and no combinational path from in_valid to in_ready.
  - No beat is ever dropped or duplicated.
- Counters:
  - cnt_single increments when a decode result with out_single transfers on the output. cnt_double does the same for out_double.
  - Counters saturate at 2^CNT_W-1.
  - If cnt_clear and an increment occur in the same cycle, cnt_clear wins and the result is 0.
- Reset values (asynchronous on rst_n low):
  - Both stage valids, out_valid, out_word, flags, syndrome and both counters are 0.
  - in_ready is 1 one cycle after reset deasserts.
  - A beat in flight when reset asserts is lost; no output follows it.

Decomposition:
- Package secded_pkg holds:
  - functions calc_p_w(DATA_W) and pos_is_data(k);
  - functions secded_encode(data) and secded_syndrome(cw), both written as loops over positions;
  - mode enum {MODE_ENC, MODE_DEC}.
- One sub-module, secded_pipe_stage: a generic payload register with valid/ready. It is instantiated twice.

Test Plan:
- Encode, DATA_W = 16: in_data = 0x0001 -> out_word = 0x00000F after 2 cycles. in_data = 0x0000 -> 0x000000.
- Decode of codeword 0x000008 (d0 flipped from zero) -> data 0x0000, out_single = 1, syndrome = 3, cnt_single = 1.
- Decode of 0x000028 (positions 3 and 5) -> out_double = 1, syndrome = 6, out_word = 0x0003 (uncorrected), cnt_double = 1. Decode of 0x000001 -> data 0x0000, out_single = 1, syndrome = 0.
- Back-pressure: 8 back-to-back beats, out_ready toggling 1010 pattern -> all 8 results in order, each held stable while stalled, none lost.
- Counter saturation with CNT_W = 2: 5 single-error decodes -> cnt_single = 3. Then cnt_clear asserted in the same cycle as a 6th single-error transfer -> 0.
- Reset asserted mid-stream with 2 beats in flight -> out_valid = 0 and counters = 0 immediately. The next beat after reset has 2-cycle latency.
